// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared states and opcode constants for the CPU memory responder
package cpu_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        RUN,
        HALTED
    } state_e;

    localparam logic [4:0]  OP_NOP   = 5'b00000;
    localparam logic [4:0]  HALT_OP  = 5'b00001;
    localparam logic [15:0] NOP_WORD = {OP_NOP, 11'b0};

endpackage

// File: rtl/sp_ram_sync.sv
// rtl/sp_ram_sync.sv - single-port synchronous RAM, registered read, read-before-write
module sp_ram_sync #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // Read the addressed word; the write below lands after the read, so a
    // same-cycle access returns the old contents.
    always_comb begin
        rdata_d = mem[addr];
    end

    // Array write, deliberately not reset so contents survive resets.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Output register gives one cycle of read latency and a known reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - program loader, instruction/data memory and run sequencer for a CPU
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MAX_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_datain,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_dataout,
    input  logic              d_we,
    output logic [DATA_W-1:0] d_datain,
    output logic              enable,
    output logic              start,
    output logic              halted,
    output logic              timeout,
    output logic [15:0]       cycle_count
);

    localparam bit          WD_EN    = (MAX_CYCLES != 0);
    localparam logic [31:0] WD_LIMIT = WD_EN ? 32'(MAX_CYCLES - 1) : 32'd0;
    localparam logic [DATA_W-1:0] NOP_D = DATA_W'(NOP_WORD);

    state_e      state_q, state_d;
    logic        load_ready_q, load_ready_d;
    logic        enable_q, enable_d;
    logic        start_q, start_d;
    logic        halted_q, halted_d;
    logic        timeout_q, timeout_d;
    logic [15:0] count_q, count_d;

    logic              load_hs;
    logic              running;
    logic [ADDR_W-1:0] iram_addr;
    logic [DATA_W-1:0] iram_rdata;
    logic [DATA_W-1:0] dram_rdata;
    logic [15:0]       count_inc;
    logic              halt_fetch;
    logic              wd_fire;

    assign load_hs   = load_valid & load_ready_q;
    assign running   = (state_q == RUN);
    // Loading and fetching never overlap, so the iram port is shared.
    assign iram_addr = load_hs ? load_addr : i_addr;

    sp_ram_sync #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_iram (
        .clk   (clock),
        .rst_n (reset),
        .we    (load_hs),
        .addr  (iram_addr),
        .wdata (load_data),
        .rdata (iram_rdata)
    );

    sp_ram_sync #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dram (
        .clk   (clock),
        .rst_n (reset),
        .we    (d_we & running),
        .addr  (d_addr),
        .wdata (d_dataout),
        .rdata (dram_rdata)
    );

    assign i_datain   = running ? iram_rdata : NOP_D;
    assign halt_fetch = (i_datain[DATA_W-1 -: 5] == HALT_OP);
    assign count_inc  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    assign wd_fire    = WD_EN && ({16'h0, count_inc} >= WD_LIMIT);

    // Next-state and next-output computation for the load/arm/run/halt sequence.
    always_comb begin
        state_d      = state_q;
        load_ready_d = load_ready_q;
        enable_d     = enable_q;
        start_d      = 1'b0;
        halted_d     = halted_q;
        timeout_d    = timeout_q;
        count_d      = count_q;
        case (state_q)
            IDLE, LOAD, HALTED: begin
                if (load_hs) begin
                    halted_d = 1'b0;
                    if (load_last) begin
                        state_d      = ARM;
                        load_ready_d = 1'b0;
                        enable_d     = 1'b1;
                        start_d      = 1'b1;
                        timeout_d    = 1'b0;
                        count_d      = 16'd0;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            ARM: begin
                state_d = RUN;
            end
            RUN: begin
                count_d = count_inc;
                if (halt_fetch || wd_fire) begin
                    state_d      = HALTED;
                    enable_d     = 1'b0;
                    halted_d     = 1'b1;
                    load_ready_d = 1'b1;
                    // A fetched HALT takes precedence over the watchdog.
                    timeout_d    = !halt_fetch;
                end
            end
            default: begin
                state_d      = IDLE;
                load_ready_d = 1'b1;
                enable_d     = 1'b0;
                halted_d     = 1'b0;
                timeout_d    = 1'b0;
                count_d      = 16'd0;
            end
        endcase
    end

    // State and registered outputs; reset drops enable without waiting for a clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            load_ready_q <= 1'b1;
            enable_q     <= 1'b0;
            start_q      <= 1'b0;
            halted_q     <= 1'b0;
            timeout_q    <= 1'b0;
            count_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            load_ready_q <= load_ready_d;
            enable_q     <= enable_d;
            start_q      <= start_d;
            halted_q     <= halted_d;
            timeout_q    <= timeout_d;
            count_q      <= count_d;
        end
    end

    assign load_ready  = load_ready_q;
    assign enable      = enable_q;
    assign start       = start_q;
    assign halted      = halted_q;
    assign timeout     = timeout_q;
    assign cycle_count = count_q;
    assign d_datain    = dram_rdata;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - directed self-checking bench for cpu_mem_responder
module tb_cpu_mem_responder;

    localparam logic [15:0] HALT_W = 16'h0800;
    localparam logic [15:0] OR_W   = 16'h5012;

    logic        clock;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_addr;
    logic [15:0] load_data;
    logic        load_last;
    logic [7:0]  i_addr;
    logic [15:0] i_datain;
    logic [7:0]  d_addr;
    logic [15:0] d_dataout;
    logic        d_we;
    logic [15:0] d_datain;
    logic        enable;
    logic        start;
    logic        halted;
    logic        timeout;
    logic [15:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_mem_responder #(
        .ADDR_W     (8),
        .DATA_W     (16),
        .MAX_CYCLES (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_last   (load_last),
        .i_addr      (i_addr),
        .i_datain    (i_datain),
        .d_addr      (d_addr),
        .d_dataout   (d_dataout),
        .d_we        (d_we),
        .d_datain    (d_datain),
        .enable      (enable),
        .start       (start),
        .halted      (halted),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [15:0] w, input logic last);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = w;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        load_valid = 1'b0;
        load_addr  = 8'h00;
        load_data  = 16'h0000;
        load_last  = 1'b0;
        i_addr     = 8'h00;
        d_addr     = 8'h00;
        d_dataout  = 16'h0000;
        d_we       = 1'b0;
        tick();
        tick();
        n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready: got %b exp 1", load_ready); end
        n_checks++; if (i_datain !== 16'h0000) begin n_fail++; $display("FAIL reset_i_datain: got %h exp 0000", i_datain); end
        n_checks++; if (d_datain !== 16'h0000) begin n_fail++; $display("FAIL reset_d_datain: got %h exp 0000", d_datain); end
        n_checks++; if ({enable, start, halted, timeout} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b exp 0000", {enable, start, halted, timeout}); end
        n_checks++; if (cycle_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", cycle_count); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load_run();
        logic [15:0] prog [0:4];
        prog[0] = OR_W;
        prog[1] = 16'h0000;
        prog[2] = 16'h0000;
        prog[3] = 16'h0000;
        prog[4] = HALT_W;
        i_addr = 8'h00;
        load_word(8'h00, prog[0], 1'b0);
        n_checks++; if (load_ready !== 1'b1 || start !== 1'b0) begin n_fail++; $display("FAIL t1_load_state: got ready=%b start=%b exp ready=1 start=0", load_ready, start); end
        for (int k = 1; k < 4; k++) load_word(8'(k), prog[k], 1'b0);
        load_word(8'h04, prog[4], 1'b1);
        n_checks++; if (start !== 1'b1 || enable !== 1'b1) begin n_fail++; $display("FAIL t1_arm: got start=%b enable=%b exp 1 1", start, enable); end
        n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL t1_arm_ready: got %b exp 0", load_ready); end
        n_checks++; if (i_datain !== 16'h0000) begin n_fail++; $display("FAIL t1_arm_nop: got %h exp 0000", i_datain); end
        tick();
        n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL t1_start_pulse: got %b exp 0", start); end
        n_checks++; if (i_datain !== prog[0]) begin n_fail++; $display("FAIL t1_fetch0: got %h exp %h", i_datain, prog[0]); end
        for (int k = 1; k < 5; k++) begin
            i_addr = 8'(k);
            tick();
            n_checks++; if (i_datain !== prog[k]) begin n_fail++; $display("FAIL t1_fetch%0d: got %h exp %h", k, i_datain, prog[k]); end
        end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL t1_halt_early: got %b exp 0", halted); end
        tick();
        n_checks++; if (halted !== 1'b1 || enable !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL t1_halted: got h=%b en=%b to=%b exp 1 0 0", halted, enable, timeout); end
        n_checks++; if (cycle_count !== 16'd5) begin n_fail++; $display("FAIL t1_count: got %0d exp 5", cycle_count); end
        n_checks++; if (i_datain !== 16'h0000 || load_ready !== 1'b1) begin n_fail++; $display("FAIL t1_halted_outs: got i=%h ready=%b exp 0000 1", i_datain, load_ready); end
        i_addr = 8'h00;
    endtask

    task automatic test_reload_from_halted();
        i_addr = 8'h00;
        load_word(8'h00, HALT_W, 1'b1);
        n_checks++; if (halted !== 1'b0 || start !== 1'b1 || load_ready !== 1'b0) begin n_fail++; $display("FAIL t6_arm: got h=%b st=%b rdy=%b exp 0 1 0", halted, start, load_ready); end
        tick();
        n_checks++; if (i_datain !== HALT_W || halted !== 1'b0 || load_ready !== 1'b0) begin n_fail++; $display("FAIL t6_run: got i=%h h=%b rdy=%b exp 0800 0 0", i_datain, halted, load_ready); end
        tick();
        n_checks++; if (halted !== 1'b1 || cycle_count !== 16'd1) begin n_fail++; $display("FAIL t6_halted: got h=%b cnt=%0d exp 1 1", halted, cycle_count); end
    endtask

    task automatic test_dram_and_watchdog();
        int waited;
        i_addr = 8'h00;
        load_word(8'h00, 16'h0000, 1'b1);
        tick();
        d_we      = 1'b1;
        d_addr    = 8'h10;
        d_dataout = 16'hAAAA;
        tick();
        d_dataout = 16'h1212;
        tick();
        n_checks++; if (d_datain !== 16'hAAAA) begin n_fail++; $display("FAIL t2_read_before_write: got %h exp aaaa", d_datain); end
        d_we = 1'b0;
        tick();
        n_checks++; if (d_datain !== 16'h1212) begin n_fail++; $display("FAIL t2_readback: got %h exp 1212", d_datain); end
        waited = 0;
        while (halted !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++; if (waited !== 4) begin n_fail++; $display("FAIL t3_wd_latency: got %0d cycles exp 4", waited); end
        n_checks++; if (halted !== 1'b1 || timeout !== 1'b1 || enable !== 1'b0) begin n_fail++; $display("FAIL t3_wd_flags: got h=%b to=%b en=%b exp 1 1 0", halted, timeout, enable); end
        n_checks++; if (cycle_count !== 16'd7) begin n_fail++; $display("FAIL t3_wd_count: got %0d exp 7", cycle_count); end
        d_we      = 1'b1;
        d_dataout = 16'hDEAD;
        tick();
        d_we = 1'b0;
        tick();
        n_checks++; if (d_datain !== 16'h1212) begin n_fail++; $display("FAIL t3_we_ignored: got %h exp 1212", d_datain); end
    endtask

    task automatic test_halt_vs_watchdog();
        for (int k = 0; k < 6; k++) load_word(8'(k), 16'h0000, 1'b0);
        i_addr = 8'h00;
        load_word(8'h06, HALT_W, 1'b1);
        n_checks++; if (timeout !== 1'b0 || cycle_count !== 16'd0) begin n_fail++; $display("FAIL t4_arm_clear: got to=%b cnt=%0d exp 0 0", timeout, cycle_count); end
        tick();
        for (int k = 1; k < 7; k++) begin
            i_addr = 8'(k);
            tick();
        end
        n_checks++; if (i_datain !== HALT_W || halted !== 1'b0 || cycle_count !== 16'd6) begin n_fail++; $display("FAIL t4_pre: got i=%h h=%b cnt=%0d exp 0800 0 6", i_datain, halted, cycle_count); end
        tick();
        n_checks++; if (halted !== 1'b1 || timeout !== 1'b0 || cycle_count !== 16'd7) begin n_fail++; $display("FAIL t4_halt_wins: got h=%b to=%b cnt=%0d exp 1 0 7", halted, timeout, cycle_count); end
        i_addr = 8'h00;
    endtask

    task automatic test_reset_mid_run();
        i_addr = 8'h00;
        d_addr = 8'h10;
        load_word(8'h00, 16'h0000, 1'b1);
        tick();
        tick();
        #3;
        reset = 1'b0;
        #1;
        n_checks++; if (enable !== 1'b0 || load_ready !== 1'b1) begin n_fail++; $display("FAIL t5_async: got en=%b rdy=%b exp 0 1", enable, load_ready); end
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if (halted !== 1'b0 || cycle_count !== 16'd0 || i_datain !== 16'h0000) begin n_fail++; $display("FAIL t5_idle: got h=%b cnt=%0d i=%h exp 0 0 0000", halted, cycle_count, i_datain); end
        load_word(8'h09, 16'h1234, 1'b0);
        n_checks++; if (load_ready !== 1'b1 || start !== 1'b0 || enable !== 1'b0) begin n_fail++; $display("FAIL t5_load: got rdy=%b st=%b en=%b exp 1 0 0", load_ready, start, enable); end
        load_word(8'h00, 16'h0000, 1'b1);
        n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL t5_start: got %b exp 1", start); end
        tick();
        n_checks++; if (d_datain !== 16'h1212 || enable !== 1'b1) begin n_fail++; $display("FAIL t5_dram_kept: got d=%h en=%b exp 1212 1", d_datain, enable); end
        i_addr = 8'h06;
        tick();
        n_checks++; if (i_datain !== HALT_W) begin n_fail++; $display("FAIL t5_iram_kept: got %h exp 0800", i_datain); end
        tick();
        n_checks++; if (halted !== 1'b1 || timeout !== 1'b0) begin n_fail++; $display("FAIL t5_halt: got h=%b to=%b exp 1 0", halted, timeout); end
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_reload_from_halted();
        test_dram_and_watchdog();
        test_halt_vs_watchdog();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
Memory-side counterpart of the CPU's instruction and data ports. It serves i_datain from an internal instruction RAM addressed by the CPU's i_addr, and serves d_datain from and accepts d_we writes into an internal data RAM. A host-side load port fills the program image, then the block sequences enable/start to launch the CPU. It watches the fetch stream for HALT and ends the run, with a cycle-limit watchdog as backstop.

Parameters:
ADDR_W, 8, address width of both RAMs (depth 2**ADDR_W words)
DATA_W, 16, word width
MAX_CYCLES, 1024, watchdog limit on RUN cycles; 0 disables the watchdog

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
load_valid  in  1  host offers a program word
load_ready  out  1  block accepts a program word this cycle
load_addr  in  ADDR_W  instruction RAM address of the offered word
load_data  in  DATA_W  program word
load_last  in  1  marks the final program word
i_addr  in  ADDR_W  CPU fetch address (pc)
i_datain  out  DATA_W  instruction word to CPU
d_addr  in  ADDR_W  CPU data address
d_dataout  in  DATA_W  CPU store data
d_we  in  1  CPU store strobe
d_datain  out  DATA_W  load data to CPU
enable  out  1  CPU enable
start  out  1  one-cycle CPU start pulse
halted  out  1  run finished
timeout  out  1  run ended by the watchdog
cycle_count  out  16  RUN cycles elapsed, saturating

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. Outputs: load_ready=1, i_datain=NOP (16'h0000), d_datain=0, enable=0, start=0, halted=0, timeout=0, cycle_count=0. RAM contents are not cleared.
- FSM states: IDLE, LOAD, ARM, RUN, HALTED.
- IDLE: load_ready=1. A handshake (load_valid&load_ready) writes load_data into iram[load_addr].
  - Without load_last -> LOAD.
  - With load_last -> ARM.
- LOAD: load_ready=1. Each handshake writes one word. A handshake with load_last -> ARM. Cycles with load_valid=0 hold the state.
- ARM (1 cycle): load_ready=0, enable=1, start=1, halted=0, timeout=0, cycle_count cleared -> RUN.
- RUN: load_ready=0, enable=1, start=0. cycle_count increments each cycle and saturates at 16'hFFFF.
  - i_datain <= iram[i_addr], registered: address sampled at edge N, data valid after edge N, one cycle of latency.
  - d_datain <= dram[d_addr], registered, same one-cycle latency.
  - When d_we=1: dram[d_addr] <= d_dataout. A read of the same address in the same cycle returns the old data (read-before-write).
  - Registered i_datain[15:11]==HALT_OP -> HALTED on the next edge. The HALT word has still been presented to the CPU for one cycle.
  - If MAX_CYCLES!=0 and cycle_count reaches MAX_CYCLES-1 -> HALTED with timeout=1.
  - If HALT and the watchdog fire in the same cycle, HALT wins: timeout=0.
- HALTED: enable=0, halted=1, i_datain forced to NOP, d_we ignored, load_ready=1. cycle_count and timeout hold.
  - A handshake clears halted and writes the word, then -> LOAD, or -> ARM if load_last.
  - dram persists across runs.
- Outside RUN, d_we is ignored and i_datain is NOP.
- Addresses wrap modulo 2**ADDR_W with no error. The load port can write any address in any order.
- Reset asserted mid-RUN: enable drops immediately (asynchronous) and the state returns to IDLE. A partially loaded image in iram is retained.

Decomposition:
- Package cpu_mem_pkg holds:
  - state enum: IDLE, LOAD, ARM, RUN, HALTED
  - opcode constants: NOP=5'b00000, HALT_OP=5'b00001, matching the CPU's opcode encoding
  - NOP word 16'h0000
- One sub-module is natural: sp_ram_sync, a parameterised synchronous RAM with registered read and read-before-write.
  - Instantiated twice: iram, whose write port is muxed from the load port, and dram, whose write port is d_we.
- The FSM, watchdog and output muxing live in the top.

Test Plan:
1. Load 5 words at addresses 0-4 (OR 16'h?012 form, 3×NOP, HALT), last on word 4, CPU model stepping i_addr 0..4 -> start high for exactly one cycle after the last handshake. i_datain follows i_addr with 1-cycle latency. halted=1 one cycle after the HALT word appears. cycle_count=5.
2. In RUN: d_we=1, d_addr=8'h10, d_dataout=16'h1212, then read 8'h10 -> d_datain=16'h1212 one cycle after the read address. A same-cycle read of 8'h10 during the write returns the prior value.
3. MAX_CYCLES=8, program with no HALT -> halted=1, timeout=1, cycle_count=7, enable=0.
4. HALT fetched on the same cycle the watchdog expires -> halted=1, timeout=0.
5. Assert reset=0 mid-RUN between edges -> enable=0 and load_ready=1 immediately, before the next edge. After release the state is IDLE, and a new load restarts cleanly with the old dram contents intact.
6. From HALTED, load a 1-word image (HALT, load_last) at address 0 -> ARM then RUN. halted clears on the handshake and reasserts after one fetch. load_ready=0 throughout ARM/RUN.
